// File: rtl/dmux_dispatch_ctrl.sv
// dmux_dispatch_ctrl: sequencer for a 1x4 demux datapath.
// Takes one word at a time from a valid/ready input stream, parks it in a
// holding register and presents it to one of four channels (addressed or
// round-robin). A per-word wait counter drops a word whose channel never
// becomes ready, so a stalled channel cannot lock up the input.
module dmux_dispatch_ctrl #(
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [1:0]    in_dest,
    output logic [3:0]    out_valid,
    input  logic [3:0]    out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    sel,
    output logic          drop,
    output logic [CW-1:0] sent_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_e;

    // Wait counter only needs to reach TIMEOUT-1; TIMEOUT=0 disables dropping.
    localparam int unsigned   WW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned   TO_LAST   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(TO_LAST);
    localparam bit            TO_EN     = (TIMEOUT != 0);

    state_e        state_q,    state_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [1:0]    sel_q,      sel_d;
    logic [1:0]    rr_ptr_q,   rr_ptr_d;
    logic          drop_q,     drop_d;
    logic [CW-1:0] sent_cnt_q, sent_cnt_d;
    logic [WW-1:0] wait_q,     wait_d;

    logic accept;
    logic deliver;
    logic expire;

    // Handshake decode: in_ready is held low while reset is asserted.
    assign in_ready  = rst_n && en && (state_q == S_IDLE);
    assign out_valid = (state_q == S_HOLD) ? (4'b0001 << sel_q) : 4'b0000;

    assign accept  = in_valid && in_ready;
    // Only the selected channel's ready counts; the others are ignored.
    assign deliver = (state_q == S_HOLD) && out_ready[sel_q];
    // Delivery wins over an expiry landing in the same cycle.
    assign expire  = TO_EN && (state_q == S_HOLD) && !deliver && (wait_q == WAIT_LAST);

    assign out_data = out_data_q;
    assign sel      = sel_q;
    assign drop     = drop_q;
    assign sent_cnt = sent_cnt_q;

    // Next-state logic for the IDLE/HOLD sequencer and its datapath registers.
    always_comb begin
        // NOTE: every _d takes its hold value first, so no branch can leave one unassigned and infer a latch.
        state_d    = state_q;
        out_data_d = out_data_q;
        sel_d      = sel_q;
        rr_ptr_d   = rr_ptr_q;
        sent_cnt_d = sent_cnt_q;
        wait_d     = wait_q;
        drop_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    out_data_d = in_data;
                    sel_d      = mode ? rr_ptr_q : in_dest;
                    wait_d     = '0;
                    state_d    = S_HOLD;
                    if (mode) begin
                        rr_ptr_d = rr_ptr_q + 2'd1;
                    end
                end
            end
            S_HOLD: begin
                if (deliver) begin
                    sent_cnt_d = sent_cnt_q + CW'(1);
                    wait_d     = '0;
                    state_d    = S_IDLE;
                end else if (expire) begin
                    drop_d  = 1'b1;
                    wait_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset discards any held word without a drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            out_data_q <= '0;
            sel_q      <= '0;
            rr_ptr_q   <= '0;
            drop_q     <= 1'b0;
            sent_cnt_q <= '0;
            wait_q     <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
            state_q    <= state_d;
            out_data_q <= out_data_d;
            sel_q      <= sel_d;
            rr_ptr_q   <= rr_ptr_d;
            drop_q     <= drop_d;
            sent_cnt_q <= sent_cnt_d;
            wait_q     <= wait_d;
        end
    end

endmodule

// File: tb/tb_dmux_dispatch_ctrl.sv
// tb_dmux_dispatch_ctrl: directed scenarios plus randomized traffic, every
// cycle compared against a word-level behavioural model of the dispatcher.
module tb_dmux_dispatch_ctrl;

    localparam int DW = 8;
    localparam int TO = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [1:0]    in_dest;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    sel;
    logic          drop;
    logic [CW-1:0] sent_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    dmux_dispatch_ctrl #(.DW(DW), .TIMEOUT(TO), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel       (sel),
        .drop      (drop),
        .sent_cnt  (sent_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A word is either "on display" at a channel or not. It leaves when its
    // channel is ready, or after it has been shown for TO cycles unanswered.
    bit            m_held  = 0;
    logic [DW-1:0] m_data  = '0;
    int            m_sel   = 0;
    int            m_age   = 0;
    int            m_rr    = 0;
    int            m_sent  = 0;
    bit            m_drop  = 0;

    always @(posedge clk or negedge rst_n) begin : model
        bit dropped_now;
        if (!rst_n) begin
            m_held = 0; m_data = '0; m_sel = 0; m_age = 0;
            m_rr = 0; m_sent = 0; m_drop = 0;
        end else begin
            dropped_now = 0;
            if (!m_held) begin
                if (en && in_valid) begin
                    m_data = in_data;
                    if (mode) begin
                        m_sel = m_rr;
                        m_rr  = (m_rr + 1) % 4;
                    end else begin
                        m_sel = int'(in_dest);
                    end
                    m_held = 1;
                    m_age  = 0;
                end
            end else begin
                if (out_ready[m_sel]) begin
                    m_sent = (m_sent + 1) % (1 << CW);
                    m_held = 0;
                end else begin
                    m_age++;
                    if (TO != 0 && m_age == TO) begin
                        m_held      = 0;
                        dropped_now = 1;
                    end
                end
            end
            m_drop = dropped_now;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("in_ready",  {31'd0, in_ready},  {31'd0, rst_n && en && !m_held});
        check("out_valid", {28'd0, out_valid}, m_held ? (32'd1 << m_sel) : 32'd0);
        check("out_data",  {24'd0, out_data},  {24'd0, m_data});
        check("sel",       {30'd0, sel},       32'(m_sel));
        check("drop",      {31'd0, drop},      {31'd0, m_drop});
        check("sent_cnt",  {28'd0, sent_cnt},  32'(m_sent));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word and wait (bounded) for it to be taken.
    task automatic send(input logic [DW-1:0] d, input logic [1:0] dst);
        bit ok;
        ok = 0;
        step();
        in_valid = 1'b1;
        in_data  = d;
        in_dest  = dst;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("send_accept", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int vcnt;
        int dcnt;
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; in_valid = 1'b1;
        in_data = 8'hEE; in_dest = 2'd3; out_ready = 4'b0000;

        // Reset: outputs quiet even with in_valid and en high.
        repeat (2) @(negedge clk);
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_out_valid", {28'd0, out_valid}, 32'd0);
        check("rst_sel",       {30'd0, sel},       32'd0);
        check("rst_sent",      {28'd0, sent_cnt},  32'd0);
        en = 1'b1;
        #1;
        check("rst_in_ready_en", {31'd0, in_ready}, 32'd0);
        step();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // Addressed mode.
        out_ready = 4'b1111;
        send(8'hA1, 2'd2);
        @(negedge clk);
        check("addr_valid", {28'd0, out_valid}, 32'b0100);
        check("addr_sel",   {30'd0, sel},       32'd2);
        check("addr_data",  {24'd0, out_data},  32'hA1);
        step();
        @(negedge clk);
        check("addr_sent",  {28'd0, sent_cnt},  32'd1);
        check("addr_ready", {31'd0, in_ready},  32'd1);

        // Round-robin: channels 0,1,2,3 then back to 0.
        mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(8'(8'h10 + i), 2'd3);
            @(negedge clk);
            check("rr_sel",   {30'd0, sel},       32'(i % 4));
            check("rr_valid", {28'd0, out_valid}, 32'd1 << (i % 4));
        end
        step();
        @(negedge clk);
        check("rr_sent", {28'd0, sent_cnt}, 32'd6);

        // Timeout: channel 3 never ready.
        mode = 1'b0;
        out_ready = 4'b0111;
        send(8'h55, 2'd3);
        vcnt = 0;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid == 4'b1000) vcnt++;
            if (drop) dcnt++;
        end
        check("to_valid_cycles", 32'(vcnt), 32'd4);
        check("to_drop_pulses",  32'(dcnt), 32'd1);
        check("to_sent",         {28'd0, sent_cnt}, 32'd6);

        // Ready arrives on the last wait cycle: delivered, no drop.
        send(8'h56, 2'd3);
        repeat (3) step();
        out_ready = 4'b1111;
        step();
        @(negedge clk);
        check("late_sent",  {28'd0, sent_cnt},  32'd7);
        check("late_drop",  {31'd0, drop},      32'd0);
        check("late_valid", {28'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("late_drop2", {31'd0, drop}, 32'd0);

        // Wrong-channel ready, then enable dropped during HOLD.
        out_ready = 4'b1101;
        send(8'h3C, 2'd1);
        @(negedge clk);
        check("wrong_valid", {28'd0, out_valid}, 32'b0010);
        step();
        en = 1'b0; in_valid = 1'b1; in_data = 8'h77; in_dest = 2'd0;
        @(negedge clk);
        check("wrong_hold", {28'd0, out_valid}, 32'b0010);
        check("wrong_sent", {28'd0, sent_cnt},  32'd7);
        step();
        out_ready = 4'b1111;
        step();
        @(negedge clk);
        check("en0_sent",  {28'd0, sent_cnt},  32'd8);
        check("en0_ready", {31'd0, in_ready},  32'd0);
        step();
        @(negedge clk);
        check("en0_idle", {28'd0, out_valid}, 32'd0);
        step();
        en = 1'b1;
        @(negedge clk);
        check("en1_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;

        // Reset in the middle of HOLD.
        out_ready = 4'b0000;
        send(8'h99, 2'd1);
        @(negedge clk);
        check("midrst_pre", {28'd0, out_valid}, 32'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {28'd0, out_valid}, 32'd0);
        check("midrst_drop",  {31'd0, drop},      32'd0);
        check("midrst_sent",  {28'd0, sent_cnt},  32'd0);
        check("midrst_ready", {31'd0, in_ready},  32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            step();
            rst_n     = ($urandom_range(199) != 0);
            en        = ($urandom_range(9) != 0);
            mode      = 1'($urandom_range(1));
            in_valid  = ($urandom_range(3) != 0);
            in_data   = 8'($urandom);
            in_dest   = 2'($urandom);
            out_ready = ($urandom_range(7) == 0) ? 4'b1111 : (4'($urandom) & 4'($urandom));
        end
        step();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
